// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the 19-bit CPU datapath.
// Optional mem-ack watchdog: define CPU_CTRL_MEM_TIMEOUT_EN.
module cpu_control_fsm #(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned OPCODE_SIZE    = 5,
    parameter int unsigned FLAG_REG_SIZE  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic [OPCODE_SIZE-1:0]   ir_opcode,
    input  logic [1:0]               ir_dest,
    input  logic [FLAG_REG_SIZE-1:0] flags,
    input  logic                     mem_ack,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic                     load_en,
    output logic [2:0]               load_select,
    output logic                     pc_inc,
    output logic [OPCODE_SIZE-1:0]   alu_op,
    output logic                     halted,
    output logic                     bus_error,
    output logic [CNT_W-1:0]         retired
);

    localparam logic [2:0] LOAD_PC    = 3'b000;
    localparam logic [2:0] LOAD_IR    = 3'b001;
    localparam logic [2:0] LOAD_REG_A = 3'b010;
    localparam logic [2:0] LOAD_REG_B = 3'b011;
    localparam logic [2:0] LOAD_REG_C = 3'b100;

    localparam logic [OPCODE_SIZE-1:0] OpLd  = OPCODE_SIZE'(5'b10000);
    localparam logic [OPCODE_SIZE-1:0] OpSt  = OPCODE_SIZE'(5'b10001);
    localparam logic [OPCODE_SIZE-1:0] OpJmp = OPCODE_SIZE'(5'b10010);
    localparam logic [OPCODE_SIZE-1:0] OpJz  = OPCODE_SIZE'(5'b10011);
    localparam logic [OPCODE_SIZE-1:0] OpHlt = OPCODE_SIZE'(5'b11111);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StBranch,
        StBoundary,
        StHalt
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic is_alu, is_ld, is_st, is_jmp, is_jz, is_hlt;
    logic dest_valid;
    logic jump_taken;

    // Opcode classes; anything not listed falls through to NOP.
    always_comb begin
        is_alu = (ir_opcode < OpLd);
        is_ld  = (ir_opcode == OpLd);
        is_st  = (ir_opcode == OpSt);
        is_jmp = (ir_opcode == OpJmp);
        is_jz  = (ir_opcode == OpJz);
        is_hlt = (ir_opcode == OpHlt);
    end

    assign dest_valid = (ir_dest != 2'b11);
    assign jump_taken = is_jmp | (is_jz & flags[0]);

    logic unused_flags;
    assign unused_flags = ^flags[FLAG_REG_SIZE-1:1];

    function automatic logic [2:0] dest_code(input logic [1:0] dest);
        logic [2:0] code;
        code = LOAD_PC;
        case (dest)
            2'b00:   code = LOAD_REG_A;
            2'b01:   code = LOAD_REG_B;
            2'b10:   code = LOAD_REG_C;
            default: code = LOAD_PC;
        endcase
        return code;
    endfunction

`ifdef CPU_CTRL_MEM_TIMEOUT_EN
    localparam int unsigned WaitW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             bus_error_q, bus_error_d;
`endif

    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
`ifdef CPU_CTRL_MEM_TIMEOUT_EN
        bus_error_d = bus_error_q;
        wait_cnt_d  = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (mem_ack) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (is_alu) begin
                    state_d = StExec;
                end else if (is_ld || is_st) begin
                    state_d = StMem;
                end else if (is_jmp || is_jz) begin
                    state_d = StBranch;
                end else if (is_hlt) begin
                    // HLT retires on entry to HALT since it never reaches BOUNDARY.
                    state_d   = StHalt;
                    retired_d = retired_q + CNT_W'(1);
                end else begin
                    state_d = StBoundary;
                end
            end
            StExec: begin
                state_d = StBoundary;
            end
            StMem: begin
                if (mem_ack) begin
                    state_d = StBoundary;
                end
            end
            StBranch: begin
                state_d = StBoundary;
            end
            StBoundary: begin
                retired_d = retired_q + CNT_W'(1);
                state_d   = run ? StFetch : StIdle;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
`ifdef CPU_CTRL_MEM_TIMEOUT_EN
        // Counter only advances while stalled; any state change leaves it cleared.
        if ((state_q == StFetch || state_q == StMem) && !mem_ack) begin
            if (wait_cnt_q == WaitW'(TIMEOUT_CYCLES - 1)) begin
                state_d     = StHalt;
                bus_error_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + WaitW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

`ifdef CPU_CTRL_MEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign bus_error = bus_error_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign bus_error      = 1'b0;
`endif

    // State-only outputs.
    always_comb begin
        mem_req = (state_q == StFetch) || (state_q == StMem);
        mem_we  = (state_q == StMem) && is_st;
        pc_inc  = (state_q == StDecode);
        alu_op  = (state_q == StExec) ? ir_opcode : '0;
        halted  = (state_q == StHalt);
    end

    // Load bus: one target per cycle, LOAD_PC code parked when idle.
    always_comb begin
        load_en     = 1'b0;
        load_select = LOAD_PC;
        unique case (state_q)
            StFetch: begin
                if (mem_ack) begin
                    load_en     = 1'b1;
                    load_select = LOAD_IR;
                end
            end
            StExec: begin
                if (dest_valid) begin
                    load_en     = 1'b1;
                    load_select = dest_code(ir_dest);
                end
            end
            StMem: begin
                if (mem_ack && is_ld && dest_valid) begin
                    load_en     = 1'b1;
                    load_select = dest_code(ir_dest);
                end
            end
            StBranch: begin
                if (jump_taken) begin
                    load_en     = 1'b1;
                    load_select = LOAD_PC;
                end
            end
            default: begin
                load_en     = 1'b0;
                load_select = LOAD_PC;
            end
        endcase
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: directed cases plus randomized instruction stream
// checked cycle-by-cycle against an instruction-level expectation model.
module tb_cpu_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [4:0] ir_opcode;
    logic [1:0] ir_dest;
    logic [3:0] flags;
    logic       mem_ack;

    logic        mem_req, mem_we, load_en, pc_inc, halted, bus_error;
    logic [2:0]  load_select;
    logic [4:0]  alu_op;
    logic [15:0] retired;

    logic       d2_mem_req, d2_mem_we, d2_load_en, d2_pc_inc, d2_halted, d2_bus_error;
    logic [2:0] d2_load_select;
    logic [4:0] d2_alu_op;
    logic [1:0] d2_retired;

    int          tests = 0;
    int          fails = 0;
    int unsigned ret_m = 0;
    logic        exp_berr = 1'b0;

    always #5 clk = ~clk;

    cpu_control_fsm u_dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .ir_opcode  (ir_opcode),
        .ir_dest    (ir_dest),
        .flags      (flags),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .load_en    (load_en),
        .load_select(load_select),
        .pc_inc     (pc_inc),
        .alu_op     (alu_op),
        .halted     (halted),
        .bus_error  (bus_error),
        .retired    (retired)
    );

    cpu_control_fsm #(
        .CNT_W(2)
    ) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .ir_opcode  (ir_opcode),
        .ir_dest    (ir_dest),
        .flags      (flags),
        .mem_ack    (mem_ack),
        .mem_req    (d2_mem_req),
        .mem_we     (d2_mem_we),
        .load_en    (d2_load_en),
        .load_select(d2_load_select),
        .pc_inc     (d2_pc_inc),
        .alu_op     (d2_alu_op),
        .halted     (d2_halted),
        .bus_error  (d2_bus_error),
        .retired    (d2_retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check one cycle's outputs mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic e_req, input logic e_we, input logic e_ld,
                       input logic [2:0] e_sel, input logic e_inc, input logic [4:0] e_alu,
                       input logic e_halt);
        @(negedge clk);
        chk({tag, ".mem_req"}, 32'(mem_req), 32'(e_req));
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(e_we));
        chk({tag, ".load_en"}, 32'(load_en), 32'(e_ld));
        chk({tag, ".load_select"}, 32'(load_select), 32'(e_sel));
        chk({tag, ".pc_inc"}, 32'(pc_inc), 32'(e_inc));
        chk({tag, ".alu_op"}, 32'(alu_op), 32'(e_alu));
        chk({tag, ".halted"}, 32'(halted), 32'(e_halt));
        chk({tag, ".bus_error"}, 32'(bus_error), 32'(exp_berr));
        chk({tag, ".retired"}, 32'(retired), 32'(ret_m[15:0]));
        chk({tag, ".retired_w2"}, 32'(d2_retired), 32'(ret_m[1:0]));
        @(posedge clk);
        #1;
    endtask

    // 0 ALU, 1 LD, 2 ST, 3 JMP, 4 JZ, 5 HLT, 6 NOP
    function automatic int op_class(input logic [4:0] op);
        if (op < 5'd16) return 0;
        case (op)
            5'b10000: return 1;
            5'b10001: return 2;
            5'b10010: return 3;
            5'b10011: return 4;
            5'b11111: return 5;
            default:  return 6;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        run      = 1'b0;
        mem_ack  = 1'b0;
        ret_m    = 0;
        exp_berr = 1'b0;
        cyc("reset", 0, 0, 0, 3'b000, 0, 5'd0, 0);
        rst = 1'b0;
        run = 1'b1;
        cyc("idle", 0, 0, 0, 3'b000, 0, 5'd0, 0);
    endtask

    // Entered at the start of a FETCH cycle; leaves at the start of the next FETCH (or in HALT).
    task automatic run_instr(input logic [4:0] op, input logic [1:0] dest, input logic [3:0] flg,
                             input int dfetch, input int dmem, input logic run_next);
        int         c;
        logic       ld;
        logic [2:0] sel;
        c         = op_class(op);
        ir_opcode = op;
        ir_dest   = dest;
        flags     = flg;
        for (int i = 0; i <= dfetch; i++) begin
            mem_ack = (i == dfetch);
            run     = rbit();
            cyc("fetch", 1, 0, (i == dfetch), (i == dfetch) ? 3'b001 : 3'b000, 0, 5'd0, 0);
        end
        mem_ack = rbit();
        run     = rbit();
        cyc("decode", 0, 0, 0, 3'b000, 1, 5'd0, 0);
        if (c == 5) begin
            ret_m++;
            return;
        end
        if (c == 0) begin
            ld      = (dest != 2'b11);
            sel     = ld ? 3'd2 + {1'b0, dest} : 3'b000;
            mem_ack = rbit();
            cyc("exec", 0, 0, ld, sel, 0, op, 0);
        end else if (c == 1 || c == 2) begin
            for (int i = 0; i <= dmem; i++) begin
                mem_ack = (i == dmem);
                run     = rbit();
                ld      = (i == dmem) && (c == 1) && (dest != 2'b11);
                sel     = ld ? 3'd2 + {1'b0, dest} : 3'b000;
                cyc("mem", 1, (c == 2), ld, sel, 0, 5'd0, 0);
            end
        end else if (c == 3 || c == 4) begin
            ld      = (c == 3) || flg[0];
            mem_ack = rbit();
            cyc("branch", 0, 0, ld, 3'b000, 0, 5'd0, 0);
        end
        run     = run_next;
        mem_ack = rbit();
        cyc("boundary", 0, 0, 0, 3'b000, 0, 5'd0, 0);
        ret_m++;
        if (!run_next) begin
            run     = 1'b1;
            mem_ack = rbit();
            cyc("idle", 0, 0, 0, 3'b000, 0, 5'd0, 0);
        end
    endtask

    initial begin
        logic [4:0] op;
        rst       = 1'b1;
        run       = 1'b0;
        mem_ack   = 1'b0;
        ir_opcode = 5'd0;
        ir_dest   = 2'b11;
        flags     = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Directed instruction mix
        run_instr(5'b00101, 2'b01, 4'b0000, 0, 0, 1'b1);
        chk("alu_retired", 32'(retired), 32'd1);
        run_instr(5'b10000, 2'b10, 4'b0000, 0, 3, 1'b1);
        run_instr(5'b10011, 2'b00, 4'b0001, 0, 0, 1'b1);
        run_instr(5'b10011, 2'b00, 4'b0000, 0, 0, 1'b1);
        run_instr(5'b10001, 2'b00, 4'b0000, 2, 1, 1'b1);
        run_instr(5'b10010, 2'b11, 4'b0000, 1, 0, 1'b1);
        run_instr(5'b01010, 2'b11, 4'b0000, 0, 0, 1'b1);
        run_instr(5'b10000, 2'b11, 4'b0000, 0, 0, 1'b0);
        run_instr(5'b10101, 2'b00, 4'b0000, 0, 0, 1'b1);
        chk("mix_retired", 32'(retired), 32'd9);

        // Randomized stream (no HLT)
        for (int n = 0; n < 150; n++) begin
            op = 5'($urandom_range(31, 0));
            if (op == 5'b11111) op = 5'b10010;
            run_instr(op, 2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)),
                      $urandom_range(4, 0), $urandom_range(4, 0), rbit());
        end

        // Four NOPs after reset: 2-bit counter wraps
        do_reset();
        for (int n = 0; n < 4; n++) run_instr(5'b10100, 2'b00, 4'b0000, 0, 0, 1'b1);
        chk("wrap_w2", 32'(d2_retired), 32'd0);
        chk("wrap_w16", 32'(retired), 32'd4);

        // HLT: sticky, ignores run and mem_ack
        run_instr(5'b11111, 2'b00, 4'b0000, 1, 0, 1'b1);
        for (int n = 0; n < 6; n++) begin
            run     = rbit();
            mem_ack = (n % 2 == 0);
            cyc("halt", 0, 0, 0, 3'b000, 0, 5'd0, 1);
        end
        chk("halt_retired", 32'(retired), 32'd5);

        // Reset during a MEM wait
        do_reset();
        ir_opcode = 5'b10000;
        ir_dest   = 2'b00;
        mem_ack   = 1'b1;
        cyc("r_fetch", 1, 0, 1, 3'b001, 0, 5'd0, 0);
        mem_ack = 1'b0;
        cyc("r_decode", 0, 0, 0, 3'b000, 1, 5'd0, 0);
        cyc("r_mem", 1, 0, 0, 3'b000, 0, 5'd0, 0);
        #2;
        rst   = 1'b1;
        ret_m = 0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_load_en", 32'(load_en), 32'd0);
        mem_ack = 1'b1;
        cyc("rst_hold", 0, 0, 0, 3'b000, 0, 5'd0, 0);
        rst = 1'b0;
        run = 1'b0;
        cyc("rst_idle", 0, 0, 0, 3'b000, 0, 5'd0, 0);
        run = 1'b1;
        cyc("rst_idle2", 0, 0, 0, 3'b000, 0, 5'd0, 0);
        run_instr(5'b00011, 2'b10, 4'b0000, 0, 0, 1'b1);

`ifdef CPU_CTRL_MEM_TIMEOUT_EN
        // Watchdog: fetch never acknowledged
        do_reset();
        mem_ack = 1'b0;
        for (int n = 0; n < 16; n++) cyc("to_fetch", 1, 0, 0, 3'b000, 0, 5'd0, 0);
        exp_berr = 1'b1;
        for (int n = 0; n < 4; n++) begin
            mem_ack = (n == 1);
            run     = rbit();
            cyc("to_halt", 0, 0, 0, 3'b000, 0, 5'd0, 1);
        end
        chk("to_retired", 32'(retired), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Multi-cycle sequencer for the 19-bit CPU datapath.
- Runs the fetch/decode/execute loop.
- Drives the shared 3-bit LOAD_SELECT register-load bus (LOAD_PC, LOAD_IR, LOAD_REG_A/B/C codes from package constants), PC increment/load strobes, ALU opcode and the data-memory request/acknowledge handshake.
- Sits between the instruction register / flag register and the register file, ALU and memory interface.

Parameters:
- CNT_W, 16, width of retired-instruction counter (wraps).
- TIMEOUT_CYCLES, 16, memory-ack watchdog limit (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  enable instruction execution; sampled at instruction boundaries.
- ir_opcode  input  OPCODE_SIZE  opcode field of the IR.
- ir_dest  input  2  destination register field: 00=A, 01=B, 10=C, 11=none.
- flags  input  FLAG_REG_SIZE  flag register; flags[0]=Z.
- mem_ack  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory access request.
- mem_we  output  1  write qualifier, valid with mem_req.
- load_en  output  1  register load strobe.
- load_select  output  3  target register code, valid with load_en.
- pc_inc  output  1  PC += 1 strobe.
- alu_op  output  OPCODE_SIZE  ALU operation.
- halted  output  1  HALT state indicator.
- bus_error  output  1  watchdog trip (tied 0 without the feature).
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0, including retired=0 and load_select=LOAD_PC (3'b000).
- Opcode classes:
  - 00000–01111: ALU.
  - 10000: LD.
  - 10001: ST.
  - 10010: JMP.
  - 10011: JZ.
  - 11111: HLT.
  - Others: NOP.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH:
  - mem_req=1, mem_we=0, held until mem_ack.
  - In the mem_ack cycle: load_en=1, load_select=LOAD_IR; next state DECODE.
- DECODE: pc_inc=1 for exactly one cycle, then branch on class:
  - ALU → EXEC.
  - LD/ST → MEM.
  - JMP/JZ → BRANCH.
  - HLT → HALT.
  - NOP → BOUNDARY.
- EXEC:
  - alu_op=ir_opcode.
  - If ir_dest≠11: load_en=1, load_select=LOAD_REG_A/B/C per ir_dest.
  - Next state BOUNDARY. One cycle.
- MEM:
  - mem_req=1; mem_we=1 for ST.
  - Held until mem_ack. In the ack cycle, LD with ir_dest≠11 asserts load_en with the dest code.
  - Next state BOUNDARY.
- BRANCH:
  - load_en=1, load_select=LOAD_PC when JMP, or when JZ and flags[0]=1.
  - Otherwise no strobe.
  - Next state BOUNDARY.
- BOUNDARY:
  - retired increments by 1, wrapping at 2^CNT_W.
  - Next state FETCH if run=1, else IDLE.
  - run is ignored mid-instruction.
- HALT:
  - halted=1; no strobes; retired increments once on entry (HLT counts as retired).
  - Exits only via rst.
- Output timing:
  - load_en/load_select are combinational from state and mem_ack.
  - mem_req/mem_we/pc_inc/alu_op depend only on state.
  - alu_op=0 outside EXEC.
  - At most one load_en per cycle.
- mem_ack outside FETCH/MEM is ignored.
- mem_ack asserted in the first FETCH/MEM cycle completes in that cycle (zero-wait memory: fetch = 1 cycle).
- Minimum latency for an ALU instruction: FETCH, DECODE, EXEC, BOUNDARY = 4 cycles.
- rst asserted mid-instruction aborts immediately to IDLE; no partial strobes after reset.

Optional Feature:
- Macro CPU_CTRL_MEM_TIMEOUT_EN.
- Defined:
  - A counter runs while in FETCH or MEM with mem_req=1 and mem_ack=0.
  - It clears on state entry.
  - On reaching TIMEOUT_CYCLES, go to HALT with bus_error=1 sticky until rst.
  - retired does not increment for the aborted instruction.
- Undefined: no counter; bus_error tied 0; FETCH/MEM wait indefinitely.

Test Plan:
- Reset then run=1, opcode 00101, ir_dest=01, mem_ack every request cycle:
  - Cycle sequence shows FETCH load_select=001, DECODE pc_inc=1, EXEC alu_op=00101 load_select=011.
  - retired=1 after 4 cycles.
- LD with ir_dest=10, mem_ack delayed 3 cycles in MEM:
  - mem_req held 4 cycles, mem_we=0.
  - load_en with load_select=100 only in the ack cycle.
- JZ with flags=4'b0001 → load_select=000 strobe in BRANCH.
- JZ with flags=4'b0000 → no load_en in BRANCH; retired still increments.
- HLT then run toggled and mem_ack pulsed:
  - halted=1, all strobes 0, retired unchanged after entry until rst.
- rst asserted during MEM wait → outputs 0 immediately; state IDLE.
- run=0 mid-instruction → instruction completes, then IDLE.
- CNT_W=2, 4 NOPs → retired wraps to 0.
- CPU_CTRL_MEM_TIMEOUT_EN defined, mem_ack never asserted → HALT with bus_error=1 after 16 FETCH cycles; retired=0.
